// File: rtl/htif_mailbox.sv
// htif_mailbox: per-hart tohost FIFOs drained round-robin onto a tagged host stream, plus
// per-hart fromhost response registers. Exit decoding is enabled by HTIF_EXIT_DETECT_EN.
module htif_mailbox #(
    parameter int NHART  = 1,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int HID_W  = (NHART > 1) ? $clog2(NHART) : 1
) (
    input  logic                        CLK,
    input  logic                        RSTn,
    input  logic [NHART-1:0]            tohost_we,
    input  logic [NHART*DATA_W-1:0]     tohost,
    output logic [NHART-1:0]            tohost_busy,
    output logic                        host_valid,
    input  logic                        host_ready,
    output logic [HID_W-1:0]            host_hart,
    output logic [DATA_W-1:0]           host_data,
    input  logic                        resp_valid,
    input  logic [HID_W-1:0]            resp_hart,
    input  logic [DATA_W-1:0]           resp_data,
    output logic [NHART-1:0]            fromhost_valid,
    output logic [NHART*DATA_W-1:0]     fromhost,
    output logic [NHART-1:0]            overflow,
    output logic [NHART-1:0]            halted,
    output logic [NHART*(DATA_W-1)-1:0] exit_code,
    output logic                        done,
    output logic                        fail
);
    localparam int unsigned NH    = NHART;
    localparam int          PTR_W = $clog2(DEPTH);
    localparam int          CNT_W = PTR_W + 1;

    logic [DATA_W-1:0]       mem_q    [NHART][DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q [NHART];
    logic [PTR_W-1:0]        rd_ptr_q [NHART];
    logic [CNT_W-1:0]        cnt_q    [NHART];
    logic [NHART-1:0]        full, push, pop, wr_block;
    logic [NHART-1:0]        overflow_q, overflow_d;
    logic                    host_valid_q, host_valid_d;
    logic [HID_W-1:0]        host_hart_q, host_hart_d;
    logic [DATA_W-1:0]       host_data_q, host_data_d;
    logic [HID_W-1:0]        rr_q, rr_d;
    logic                    load, found;
    logic [HID_W-1:0]        gnt;
    logic [DATA_W-1:0]       gnt_data;
    int unsigned             scan;
    logic [NHART-1:0]        fv_q, fv_d;
    logic [NHART*DATA_W-1:0] fromhost_q, fromhost_d;

    // Round-robin search starts one past the last granted hart.
    always_comb begin
        load     = !host_valid_q || host_ready;
        found    = 1'b0;
        gnt      = '0;
        gnt_data = '0;
        scan     = 0;
        for (int unsigned i = 1; i <= NH; i++) begin
            scan = (32'(rr_q) + i) % NH;
            if (!found && cnt_q[scan] != '0) begin
                found    = 1'b1;
                gnt      = HID_W'(scan);
                gnt_data = mem_q[scan][rd_ptr_q[scan]];
            end
        end
    end

    always_comb begin
        for (int unsigned h = 0; h < NH; h++) begin
            full[h]       = (cnt_q[h] == CNT_W'(DEPTH));
            pop[h]        = load && found && (gnt == HID_W'(h));
            push[h]       = tohost_we[h] && !wr_block[h] && (!full[h] || pop[h]);
            overflow_d[h] = overflow_q[h] | (tohost_we[h] && !wr_block[h] && full[h] && !pop[h]);
        end
    end

    always_comb begin
        host_valid_d = host_valid_q;
        host_hart_d  = host_hart_q;
        host_data_d  = host_data_q;
        rr_d         = rr_q;
        if (load) begin
            host_valid_d = found;
            if (found) begin
                host_hart_d = gnt;
                host_data_d = gnt_data;
                rr_d        = gnt;
            end
        end
    end

    always_comb begin
        fv_d       = '0;
        fromhost_d = fromhost_q;
        for (int unsigned h = 0; h < NH; h++) begin
            if (resp_valid && resp_hart == HID_W'(h)) begin
                fv_d[h]                          = 1'b1;
                fromhost_d[h*DATA_W +: DATA_W] = resp_data;
            end
        end
    end

    always_ff @(posedge CLK) begin
        for (int unsigned h = 0; h < NH; h++) begin
            if (push[h]) mem_q[h][wr_ptr_q[h]] <= tohost[h*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned h = 0; h < NH; h++) begin
                wr_ptr_q[h] <= '0;
                rd_ptr_q[h] <= '0;
                cnt_q[h]    <= '0;
            end
            overflow_q   <= '0;
            host_valid_q <= 1'b0;
            host_hart_q  <= '0;
            host_data_q  <= '0;
            rr_q         <= HID_W'(NHART - 1);
            fv_q         <= '0;
            fromhost_q   <= '0;
        end else begin
            for (int unsigned h = 0; h < NH; h++) begin
                if (push[h]) wr_ptr_q[h] <= wr_ptr_q[h] + 1'b1;
                if (pop[h])  rd_ptr_q[h] <= rd_ptr_q[h] + 1'b1;
                cnt_q[h] <= cnt_q[h] + CNT_W'(push[h]) - CNT_W'(pop[h]);
            end
            overflow_q   <= overflow_d;
            host_valid_q <= host_valid_d;
            host_hart_q  <= host_hart_d;
            host_data_q  <= host_data_d;
            rr_q         <= rr_d;
            fv_q         <= fv_d;
            fromhost_q   <= fromhost_d;
        end
    end

    assign tohost_busy    = full;
    assign overflow       = overflow_q;
    assign host_valid     = host_valid_q;
    assign host_hart      = host_hart_q;
    assign host_data      = host_data_q;
    assign fromhost_valid = fv_q;
    assign fromhost       = fromhost_q;

`ifdef HTIF_EXIT_DETECT_EN
    logic [NHART-1:0]            halted_q, halted_d;
    logic [NHART*(DATA_W-1)-1:0] exit_code_q, exit_code_d;
    logic                        done_q, fail_q;

    always_comb begin
        halted_d    = halted_q;
        exit_code_d = exit_code_q;
        for (int unsigned h = 0; h < NH; h++) begin
            if (push[h] && tohost[h*DATA_W]) begin
                halted_d[h]                                = 1'b1;
                exit_code_d[h*(DATA_W-1) +: (DATA_W-1)] = tohost[h*DATA_W+1 +: (DATA_W-1)];
            end
        end
    end

    // done/fail look at the registered halt state, so they trail the last halt by one edge.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            halted_q    <= '0;
            exit_code_q <= '0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
        end else begin
            halted_q    <= halted_d;
            exit_code_q <= exit_code_d;
            done_q      <= &halted_q;
            fail_q      <= (&halted_q) && (|exit_code_q);
        end
    end

    assign wr_block  = halted_q;
    assign halted    = halted_q;
    assign exit_code = exit_code_q;
    assign done      = done_q;
    assign fail      = fail_q;
`else
    assign wr_block  = '0;
    assign halted    = '0;
    assign exit_code = '0;
    assign done      = 1'b0;
    assign fail      = 1'b0;
`endif

endmodule

// File: tb/tb_htif_mailbox.sv
// Self-checking bench for htif_mailbox (3 harts, 32-bit words, depth 4): directed scenarios
// plus randomized traffic compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_htif_mailbox;
    localparam int NH  = 3;
    localparam int DW  = 32;
    localparam int DEP = 4;
    localparam int HW  = 2;
`ifdef HTIF_EXIT_DETECT_EN
    localparam bit EXIT_EN = 1'b1;
`else
    localparam bit EXIT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NH-1:0]     tohost_we = '0;
    logic [NH*DW-1:0]  tohost = '0;
    logic [NH-1:0]     tohost_busy;
    logic              host_valid;
    logic              host_ready = 1'b0;
    logic [HW-1:0]     host_hart;
    logic [DW-1:0]     host_data;
    logic              resp_valid = 1'b0;
    logic [HW-1:0]     resp_hart = '0;
    logic [DW-1:0]     resp_data = '0;
    logic [NH-1:0]     fromhost_valid;
    logic [NH*DW-1:0]  fromhost;
    logic [NH-1:0]     overflow;
    logic [NH-1:0]     halted;
    logic [NH*(DW-1)-1:0] exit_code;
    logic              done;
    logic              fail;

    int total = 0;
    int bad   = 0;

    htif_mailbox #(.NHART(NH), .DATA_W(DW), .DEPTH(DEP)) dut (
        .CLK(clk), .RSTn(rst_n),
        .tohost_we(tohost_we), .tohost(tohost), .tohost_busy(tohost_busy),
        .host_valid(host_valid), .host_ready(host_ready),
        .host_hart(host_hart), .host_data(host_data),
        .resp_valid(resp_valid), .resp_hart(resp_hart), .resp_data(resp_data),
        .fromhost_valid(fromhost_valid), .fromhost(fromhost),
        .overflow(overflow), .halted(halted), .exit_code(exit_code),
        .done(done), .fail(fail)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed { logic [7:0] hart; logic [DW-1:0] data; } ent_t;
    ent_t          mq[$];
    logic          m_valid;
    logic [HW-1:0] m_hart;
    logic [DW-1:0] m_data;
    int            m_rr;
    logic [NH-1:0] m_ovf, m_halt, m_fv;
    logic [DW-2:0] m_code [NH];
    logic [DW-1:0] m_fh   [NH];
    logic          m_done, m_fail;
    bit            ld, old_all, old_any, got;
    int            g, c;
    logic [DW-1:0] pw, d;

    function automatic int cnt_of(input int h);
        int n = 0;
        foreach (mq[k]) if (int'(mq[k].hart) == h) n++;
        return n;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_valid = 0; m_hart = '0; m_data = '0; m_rr = NH - 1;
                m_ovf = '0; m_halt = '0; m_fv = '0; m_done = 0; m_fail = 0;
                for (int h = 0; h < NH; h++) begin m_code[h] = '0; m_fh[h] = '0; end
            end else begin
                ld = !m_valid || host_ready;
                g  = -1;
                if (ld) for (int i = 1; i <= NH; i++) begin
                    c = (m_rr + i) % NH;
                    if (g < 0 && cnt_of(c) > 0) g = c;
                end
                if (g >= 0) begin
                    got = 0;
                    for (int k = 0; k < mq.size(); k++)
                        if (!got && int'(mq[k].hart) == g) begin
                            pw = mq[k].data; mq.delete(k); got = 1;
                        end
                end
                old_all = &m_halt;
                old_any = 0;
                for (int h = 0; h < NH; h++) if (m_code[h] != 0) old_any = 1;
                for (int h = 0; h < NH; h++) if (tohost_we[h]) begin
                    d = tohost[h*DW +: DW];
                    if (EXIT_EN && m_halt[h]) begin
                        // silently dropped after exit
                    end else if (cnt_of(h) < DEP) begin
                        mq.push_back('{hart: 8'(h), data: d});
                        if (EXIT_EN && d[0]) begin m_halt[h] = 1; m_code[h] = d[DW-1:1]; end
                    end else m_ovf[h] = 1;
                end
                m_done = EXIT_EN && old_all;
                m_fail = EXIT_EN && old_all && old_any;
                if (ld) begin
                    m_valid = (g >= 0);
                    if (g >= 0) begin m_hart = HW'(g); m_data = pw; m_rr = g; end
                end
                m_fv = '0;
                if (resp_valid && int'(resp_hart) < NH) begin
                    m_fh[resp_hart] = resp_data; m_fv[resp_hart] = 1;
                end
            end
        end
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic tick();
        @(posedge clk); @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; tohost_we = '0; tohost = '0; host_ready = 0;
        resp_valid = 0; resp_hart = '0; resp_data = '0;
        tick(); tick();
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", host_valid); end
        total++; if (host_data !== '0 || host_hart !== '0) begin bad++; $display("FAIL reset_hostreg got=%0h/%0d exp=0/0", host_data, host_hart); end
        total++; if (tohost_busy !== '0 || overflow !== '0) begin bad++; $display("FAIL reset_busy_ovf got=%b/%b exp=0/0", tohost_busy, overflow); end
        total++; if (fromhost !== '0 || fromhost_valid !== '0) begin bad++; $display("FAIL reset_fromhost got=%0h/%b exp=0", fromhost, fromhost_valid); end
        total++; if (halted !== '0 || exit_code !== '0 || done !== 0 || fail !== 0) begin bad++; $display("FAIL reset_exit got=%b/%0h/%b/%b exp=0", halted, exit_code, done, fail); end
    endtask

    task automatic test_latency();
        do_reset();
        host_ready = 1;
        tohost_we = 3'b001; tohost[31:0] = 32'h10;
        tick();
        tohost_we = '0;
        total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL lat_edge0 got=%b exp=0", host_valid); end
        tick();
        total++; if (host_valid !== 1'b1 || host_data !== 32'h10 || host_hart !== 2'd0) begin
            bad++; $display("FAIL lat_edge1 got=%b/%0h/%0d exp=1/10/0", host_valid, host_data, host_hart); end
        tick();
        total++; if (host_valid !== 1'b0) begin bad++; $display("FAIL lat_edge2 got=%b exp=0", host_valid); end
    endtask

    task automatic test_overflow();
        logic [DW-1:0] exp_seq [5];
        exp_seq[0] = 32'hA0;
        for (int i = 1; i < 5; i++) exp_seq[i] = DW'(i);
        do_reset();
        tohost_we = 3'b001; tohost[31:0] = 32'hA0;
        tick(); tohost_we = '0; tick();
        for (int k = 1; k <= 5; k++) begin
            tohost_we = 3'b001; tohost[31:0] = DW'(k);
            tick();
            if (k == 3) begin total++; if (tohost_busy[0] !== 1'b0) begin bad++; $display("FAIL ovf_busy3 got=%b exp=0", tohost_busy[0]); end end
            if (k == 4) begin total++; if (tohost_busy[0] !== 1'b1 || overflow[0] !== 1'b0) begin bad++; $display("FAIL ovf_full4 busy=%b ovf=%b exp=1/0", tohost_busy[0], overflow[0]); end end
            if (k == 5) begin total++; if (overflow !== 3'b001) begin bad++; $display("FAIL ovf_set got=%b exp=001", overflow); end end
        end
        tohost_we = '0; host_ready = 1;
        for (int i = 0; i < 5; i++) begin
            total++; if (host_valid !== 1'b1 || host_data !== exp_seq[i]) begin
                bad++; $display("FAIL ovf_drain%0d got=%b/%0h exp=1/%0h", i, host_valid, host_data, exp_seq[i]); end
            tick();
        end
        total++; if (host_valid !== 1'b0 || overflow !== 3'b001) begin bad++; $display("FAIL ovf_after got=%b/%b exp=0/001", host_valid, overflow); end
    endtask

    task automatic test_full_pop();
        do_reset();
        tohost_we = 3'b010; tohost[63:32] = 32'hB0;
        tick(); tohost_we = '0; tick();
        for (int k = 1; k <= 4; k++) begin tohost_we = 3'b010; tohost[63:32] = DW'(k); tick(); end
        total++; if (tohost_busy !== 3'b010) begin bad++; $display("FAIL fp_full got=%b exp=010", tohost_busy); end
        host_ready = 1; tohost_we = 3'b010; tohost[63:32] = 32'h5;
        tick();
        tohost_we = '0;
        total++; if (overflow !== 3'b000 || tohost_busy !== 3'b010) begin bad++; $display("FAIL fp_accept ovf=%b busy=%b exp=000/010", overflow, tohost_busy); end
        for (int i = 1; i <= 5; i++) begin
            total++; if (host_valid !== 1'b1 || host_data !== DW'(i) || host_hart !== 2'd1) begin
                bad++; $display("FAIL fp_drain%0d got=%b/%0h/%0d exp=1/%0h/1", i, host_valid, host_data, host_hart, i); end
            tick();
        end
    endtask

    task automatic test_round_robin();
        int e;
        do_reset();
        host_ready = 1;
        for (int cyc = 0; cyc < 12; cyc++) begin
            tohost_we = 3'b111;
            for (int h = 0; h < NH; h++) tohost[h*DW +: DW] = (h << 24) | cyc;
            tick();
            if (cyc >= 1) begin
                e = (cyc - 1) % NH;
                total++; if (host_valid !== 1'b1 || host_hart !== HW'(e) || host_data !== DW'((e << 24) | ((cyc - 1) / NH))) begin
                    bad++; $display("FAIL rr_c%0d got=%b/%0d/%0h exp=1/%0d/%0h", cyc, host_valid, host_hart, host_data, e, (e << 24) | ((cyc - 1) / NH)); end
            end
        end
        tohost_we = '0;
    endtask

    task automatic test_response();
        do_reset();
        resp_valid = 1; resp_hart = 2'd1; resp_data = 32'hABCD;
        tick();
        resp_valid = 0;
        total++; if (fromhost[63:32] !== 32'hABCD || fromhost_valid !== 3'b010) begin
            bad++; $display("FAIL resp_load got=%0h/%b exp=abcd/010", fromhost[63:32], fromhost_valid); end
        total++; if (fromhost[31:0] !== '0 || fromhost[95:64] !== '0) begin bad++; $display("FAIL resp_others got=%0h exp=0", fromhost); end
        tick();
        total++; if (fromhost_valid !== 3'b000 || fromhost[63:32] !== 32'hABCD) begin
            bad++; $display("FAIL resp_pulse got=%b/%0h exp=000/abcd", fromhost_valid, fromhost[63:32]); end
        resp_valid = 1; resp_hart = 2'd3; resp_data = 32'h1234;
        tick();
        total++; if (fromhost_valid !== 3'b000 || fromhost[95:64] !== '0 || fromhost[63:32] !== 32'hABCD) begin
            bad++; $display("FAIL resp_oob got=%b/%0h exp=000", fromhost_valid, fromhost); end
        resp_hart = 2'd1; resp_data = 32'h5555;
        tick();
        resp_valid = 0;
        total++; if (fromhost[63:32] !== 32'h5555 || fromhost_valid !== 3'b010) begin
            bad++; $display("FAIL resp_overwrite got=%0h/%b exp=5555/010", fromhost[63:32], fromhost_valid); end
    endtask

    task automatic test_exit();
        int n;
        logic [HW-1:0] hs [8];
        logic [DW-1:0] ds [8];
        do_reset();
        host_ready = 1;
        tohost_we = 3'b111; tohost[31:0] = 32'h7; tohost[63:32] = 32'h1; tohost[95:64] = 32'h1;
        tick();
        tohost_we = 3'b001; tohost[31:0] = 32'h20;
`ifdef HTIF_EXIT_DETECT_EN
        total++; if (halted !== 3'b111 || exit_code[30:0] !== 31'd3 || exit_code[92:31] !== '0 || done !== 1'b0) begin
            bad++; $display("FAIL exit_halt got=%b/%0h/%b exp=111/3/0", halted, exit_code, done); end
`else
        total++; if (halted !== 3'b000 || exit_code !== '0 || done !== 1'b0) begin
            bad++; $display("FAIL exit_tied got=%b/%0h/%b exp=0", halted, exit_code, done); end
`endif
        tick();
        tohost_we = '0;
`ifdef HTIF_EXIT_DETECT_EN
        total++; if (done !== 1'b1 || fail !== 1'b1) begin bad++; $display("FAIL exit_done got=%b/%b exp=1/1", done, fail); end
`else
        total++; if (done !== 1'b0 || fail !== 1'b0) begin bad++; $display("FAIL exit_done_tied got=%b/%b exp=0/0", done, fail); end
`endif
        n = 0;
        for (int i = 0; i < 7; i++) begin
            if (host_valid === 1'b1 && n < 8) begin hs[n] = host_hart; ds[n] = host_data; n++; end
            tick();
        end
        total++; if (n !== (EXIT_EN ? 3 : 4)) begin bad++; $display("FAIL exit_count got=%0d exp=%0d", n, EXIT_EN ? 3 : 4); end
        total++; if (n >= 3 && (hs[0] !== 2'd0 || ds[0] !== 32'h7 || hs[1] !== 2'd1 || ds[1] !== 32'h1 || hs[2] !== 2'd2 || ds[2] !== 32'h1)) begin
            bad++; $display("FAIL exit_words got=%0d:%0h %0d:%0h %0d:%0h exp=0:7 1:1 2:1", hs[0], ds[0], hs[1], ds[1], hs[2], ds[2]); end
        total++; if (overflow !== 3'b000) begin bad++; $display("FAIL exit_ovf got=%b exp=000", overflow); end
    endtask

    task automatic test_random();
        logic [NH-1:0] exp_busy;
        logic [NH*DW-1:0] exp_fh;
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            tohost_we  = NH'($urandom_range(0, 7));
            for (int h = 0; h < NH; h++) tohost[h*DW +: DW] = $urandom & 32'hFFFF_FFFE;
            host_ready = ($urandom_range(0, 3) != 0);
            resp_valid = ($urandom_range(0, 3) == 0);
            resp_hart  = HW'($urandom_range(0, 3));
            resp_data  = $urandom;
            tick();
            for (int h = 0; h < NH; h++) begin
                exp_busy[h] = (cnt_of(h) == DEP);
                exp_fh[h*DW +: DW] = m_fh[h];
            end
            total++; if (host_valid !== m_valid || (m_valid && (host_hart !== m_hart || host_data !== m_data))) begin
                bad++; $display("FAIL rnd_stream c%0d got=%b/%0d/%0h exp=%b/%0d/%0h", cyc, host_valid, host_hart, host_data, m_valid, m_hart, m_data); end
            total++; if (tohost_busy !== exp_busy || overflow !== m_ovf) begin
                bad++; $display("FAIL rnd_busy_ovf c%0d got=%b/%b exp=%b/%b", cyc, tohost_busy, overflow, exp_busy, m_ovf); end
            total++; if (fromhost_valid !== m_fv || fromhost !== exp_fh) begin
                bad++; $display("FAIL rnd_resp c%0d got=%b/%0h exp=%b/%0h", cyc, fromhost_valid, fromhost, m_fv, exp_fh); end
            total++; if (halted !== m_halt || done !== m_done || fail !== m_fail) begin
                bad++; $display("FAIL rnd_exit c%0d got=%b/%b/%b exp=%b/%b/%b", cyc, halted, done, fail, m_halt, m_done, m_fail); end
        end
        tohost_we = '0; resp_valid = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        tohost_we = 3'b100; tohost[95:64] = 32'h55;
        tick(); tohost_we = 3'b100; tick(); tohost_we = '0;
        total++; if (host_valid !== 1'b1 || host_data !== 32'h55 || host_hart !== 2'd2) begin
            bad++; $display("FAIL arst_pre got=%b/%0h/%0d exp=1/55/2", host_valid, host_data, host_hart); end
        #2 rst_n = 0;
        #1;
        total++; if (host_valid !== 1'b0 || host_data !== '0 || host_hart !== '0 || tohost_busy !== '0) begin
            bad++; $display("FAIL arst_clear got=%b/%0h/%0d/%b exp=0/0/0/000", host_valid, host_data, host_hart, tohost_busy); end
        @(negedge clk); rst_n = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_full_pop();
        test_round_robin();
        test_response();
        test_exit();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/htif_mailbox.md
# htif_mailbox

Parametrised host-target mailbox sitting between one or more simulated/implemented harts and the testbench host. Each hart pushes `tohost` words into its own FIFO; a round-robin arbiter drains them onto a single valid/ready host stream tagged with hart id. The host returns `fromhost` words per hart, and exit words (LSB=1) are decoded into per-hart halt status and a global done flag.

## Interface
- `NHART`, default 1: number of hart channels (1..16).
- `DATA_W`, default 32: width of tohost/fromhost words (32 or 64).
- `DEPTH`, default 4: per-hart FIFO depth, power of two, ≥2.
- `HID_W`, default `$clog2(NHART)` (min 1): hart id width.

Ports:
- `CLK` in 1: clock; everything is on the rising edge.
- `RSTn` in 1: reset, asynchronous, active-low.
- `tohost_we` in NHART: per-hart write strobe.
- `tohost` in NHART*DATA_W: per-hart write data; hart h occupies bits [h*DATA_W +: DATA_W].
- `tohost_busy` out NHART: hart h FIFO full.
- `host_valid` out 1: host stream word valid.
- `host_ready` in 1: host accepts word.
- `host_hart` out HID_W: source hart of `host_data`.
- `host_data` out DATA_W: word to host.
- `resp_valid` in 1: host response strobe.
- `resp_hart` in HID_W: response target hart.
- `resp_data` in DATA_W: response word.
- `fromhost_valid` out NHART: one-cycle pulse per hart.
- `fromhost` out NHART*DATA_W: per-hart response register, packed like `tohost`.
- `overflow` out NHART: sticky, write dropped while full.
- `halted` out NHART: hart h has written an exit word.
- `exit_code` out NHART*(DATA_W-1): per-hart exit code, which is the exit word >> 1.
- `done` out 1: all harts halted.
- `fail` out 1: done and any exit_code ≠ 0.

## Operation
- Reset values: all FIFOs empty; `host_valid`=0; `host_hart`/`host_data`=0; `fromhost_valid`=0; `fromhost`=0; `overflow`=0; `halted`=0; `exit_code`=0; `done`=0; `fail`=0; RR pointer=NHART-1, so hart 0 has first priority.
- Enqueue: `tohost_we[h]` sampled at the edge.
  - Accepted if FIFO h is not full, or it is full and is popped at the same edge.
  - If full with no pop: word dropped and `overflow[h]` set. The flag stays set until reset.
  - After `halted[h]`, further writes from h are dropped silently, with no overflow.
- `tohost_busy[h]` = FIFO h count == DEPTH, combinational from the registered count.
- Output register loads when `host_valid`=0 or (`host_valid` & `host_ready`).
  - It selects the first non-empty FIFO searching from RR pointer+1 upward, modulo NHART.
  - It pops that FIFO, loads `host_hart`/`host_data` and sets `host_valid`.
  - The RR pointer updates to the granted hart.
  - If all FIFOs are empty, `host_valid` clears after an accepted word.
- `host_data`/`host_hart` are held stable while `host_valid` & !`host_ready`.
- Response: when `resp_valid`, `fromhost[resp_hart]` is loaded with `resp_data` and `fromhost_valid[resp_hart]` pulses high for one cycle. A `resp_hart` ≥ NHART is ignored. A new response to the same hart overwrites the register.
- Exit: an accepted enqueue with bit0=1 sets `halted[h]` and captures `exit_code[h]`=data[DATA_W-1:1]. The word is still enqueued and forwarded to the host.
- `done` is registered: it equals AND(`halted`), one edge after the last halt is set. `fail` is registered alongside it.

## Timing
- Write at edge k: `host_valid` is high after edge k+1 when the stream is idle. Minimum latency is 2 edges, and the second edge is the output load.
- Throughput is one word per cycle with `host_ready` held high.
- Response at edge k: `fromhost`/`fromhost_valid` are visible after edge k, and the pulse clears after edge k+1.
- Halt at edge k: `halted` is visible after k, `done` after k+1.
- An asynchronous `RSTn` assertion mid-transfer clears everything immediately, including a word held on the host stream.

## Configuration
- `HTIF_EXIT_DETECT_EN`
  - Defined: exit decoding, `halted`, `exit_code`, `done` and `fail` behave as above.
  - Undefined: all words are plain data. `halted`, `exit_code`, `done` and `fail` are tied to 0, and post-exit write dropping is absent.

## Test plan
- NHART=1, DEPTH=4, `host_ready`=1, write 0x10 at edge 0 -> `host_valid`=1, `host_data`=0x10 and `host_hart`=0 after edge 1, low after edge 2.
- `host_ready`=0, five writes 1..5 -> `tohost_busy`=1 after the fourth FIFO entry; 5th write sets `overflow`. Drain order is 1,2,3,4, and one word is held on the output.
- NHART=3, all harts write every cycle, `host_ready`=1 -> `host_hart` sequence is 0,1,2,0,1,2….
- Full FIFO, write and pop at the same edge -> write accepted, `overflow` stays 0.
- Hart 1 writes 0x1 and hart 0 writes 0x7 (NHART=2) -> `halted`=2'b11, `exit_code[0]`=3, `done`=1 and `fail`=1 one edge later. A subsequent write from hart 0 is not enqueued.
- `resp_valid`, `resp_hart`=1, `resp_data`=0xABCD -> `fromhost[1]`=0xABCD and `fromhost_valid`=2'b10 for exactly one cycle.
